// File: rtl/text_scanout_fetcher.sv
// text_scanout_fetcher
//
// Read side of the 80x30 text display. Takes the timing generator's pixel
// coordinates, fetches the character code from VRAM, then the glyph row from
// the font ROM, and emits one RGB332 pixel per clock. A blinking underline
// cursor is overlaid on the last two glyph lines of the cursor cell.
// Total latency from pixel input to rgb_out is fixed at LAT = 5 clocks.
// The syncs and the active flag pass through delay lines of the same depth.
//
// Ports:
//   clk, rst              system clock; synchronous active-low reset
//   pix_x, pix_y          pixel coordinates from the timing generator
//   pix_active            visible-area flag
//   h_sync_in, v_sync_in  syncs from the timing generator
//   vram_read_address     character cell address (row*80+col), registered
//   vram_read_data        ASCII code, valid one clock after the address
//   font_address          {ascii, glyph_line}, registered
//   font_data             glyph row, bit 7 = leftmost, valid one clock later
//   color_data            [7:0] foreground, [15:8] background (RGB332)
//   cursor_en, cursor_col, cursor_row   cursor control
//   rgb_out               RGB332 pixel
//   h_sync_out, v_sync_out, active_out  inputs delayed by LAT clocks

module text_scanout_fetcher #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_active,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic [11:0] vram_read_address,
    input  logic [7:0]  vram_read_data,
    output logic [11:0] font_address,
    input  logic [7:0]  font_data,
    input  logic [15:0] color_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [7:0]  rgb_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        active_out
);

    localparam int          LAT        = 5;
    localparam logic [6:0]  COLS_LIM   = 7'(COLS);
    localparam logic [4:0]  ROWS_LIM   = 5'(ROWS);
    localparam logic [4:0]  BLINK_LAST = 5'(BLINK_FRAMES - 1);

    // Pixel decode (stage 0)
    logic [6:0]  col;
    logic [4:0]  row;
    logic [3:0]  glyph_line;
    logic [2:0]  sub;
    logic        in_range;
    logic [11:0] cell_address;
    logic        cursor_hit;
    logic        unused_pix_y;

    // Stage 1..4 carried fields
    logic [3:0]  line_s1, line_s2;
    logic [2:0]  sub_s1, sub_s2, sub_s3, sub_s4;
    logic        inr_s1, inr_s2, inr_s3, inr_s4;
    logic        cur_s1, cur_s2, cur_s3, cur_s4;

    // LAT-deep delay lines for syncs and the active flag
    logic [LAT-1:0] hs_sr, vs_sr, act_sr;

    // Blink state
    logic        vs_prev;
    logic [4:0]  frame_count;
    logic        blink_phase;
    logic        frame_event;

    assign col          = pix_x[9:3];
    assign row          = pix_y[8:4];
    assign glyph_line   = pix_y[3:0];
    assign sub          = pix_x[2:0];
    // Only 30 rows exist, so pix_y[9] has no role in addressing.
    assign unused_pix_y = pix_y[9];

    assign in_range = pix_active && (col < COLS_LIM) && (row < ROWS_LIM);

    // row*80 as row*64 + row*16, so no multiplier is needed.
    assign cell_address = 12'({row, 6'b0}) + 12'({row, 4'b0}) + 12'(col);

    // Gating with in_range keeps an off-screen cursor position from ever matching.
    assign cursor_hit = cursor_en && blink_phase && in_range
                        && (col == cursor_col) && (row == cursor_row)
                        && (glyph_line >= 4'd14);

    assign frame_event = v_sync_in && !vs_prev;

    // Address pipeline: VRAM address out at T+1, the returned character
    // forms the font address at T+3, and the glyph row is consumed at T+4.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vram_read_address <= 12'd0;
            font_address      <= 12'd0;
            line_s1 <= 4'd0;  line_s2 <= 4'd0;
            sub_s1  <= 3'd0;  sub_s2  <= 3'd0;  sub_s3 <= 3'd0;  sub_s4 <= 3'd0;
            inr_s1  <= 1'b0;  inr_s2  <= 1'b0;  inr_s3 <= 1'b0;  inr_s4 <= 1'b0;
            cur_s1  <= 1'b0;  cur_s2  <= 1'b0;  cur_s3 <= 1'b0;  cur_s4 <= 1'b0;
        end else begin
            vram_read_address <= in_range ? cell_address : 12'd0;
            line_s1 <= glyph_line;
            sub_s1  <= sub;
            inr_s1  <= in_range;
            cur_s1  <= cursor_hit;

            line_s2 <= line_s1;
            sub_s2  <= sub_s1;
            inr_s2  <= inr_s1;
            cur_s2  <= cur_s1;

            font_address <= {vram_read_data, line_s2};
            sub_s3  <= sub_s2;
            inr_s3  <= inr_s2;
            cur_s3  <= cur_s2;

            sub_s4  <= sub_s3;
            inr_s4  <= inr_s3;
            cur_s4  <= cur_s3;
        end
    end

    // Sync and active delay lines. They are plain shift registers, so sync
    // polarity is preserved.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_sr  <= '0;
            vs_sr  <= '0;
            act_sr <= '0;
        end else begin
            hs_sr  <= {hs_sr[LAT-2:0],  h_sync_in};
            vs_sr  <= {vs_sr[LAT-2:0],  v_sync_in};
            act_sr <= {act_sr[LAT-2:0], pix_active};
        end
    end

    assign h_sync_out = hs_sr[LAT-1];
    assign v_sync_out = vs_sr[LAT-1];
    assign active_out = act_sr[LAT-1];

    // Final pixel select. ~sub_s4 equals 7-sub, so bit 7 is the leftmost pixel.
    // color_data is sampled here, so a colour change shows on the next output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_out <= 8'h00;
        end else if (!act_sr[LAT-2]) begin
            rgb_out <= 8'h00;
        end else if (inr_s4 && (font_data[~sub_s4] || cur_s4)) begin
            rgb_out <= color_data[7:0];
        end else begin
            rgb_out <= color_data[15:8];
        end
    end

    // Blink timer: counts rising edges of v_sync_in, and flips the cursor
    // phase every BLINK_FRAMES frames. The phase starts hidden after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vs_prev     <= 1'b0;
            frame_count <= 5'd0;
            blink_phase <= 1'b0;
        end else begin
            vs_prev <= v_sync_in;
            if (frame_event) begin
                if (frame_count == BLINK_LAST) begin
                    frame_count <= 5'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_count <= frame_count + 5'd1;
                end
            end
        end
    end

endmodule

// File: doc/text_scanout_fetcher.md
Name: text_scanout_fetcher

Overview:
- Read-side counterpart to the VRAM write path (CPU writes and clear engine).
- Converts the display timing generator's pixel coordinates into VRAM character reads and font ROM row reads for an 80x30 text screen of 8x16 glyphs (640x480).
- Produces one RGB332 pixel per clock, with syncs and the active flag delayed to stay aligned with the pixel.
- Adds a blinking underline cursor.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, character rows
- BLINK_FRAMES, 32, frames per cursor blink half-period
- LAT, 5, fixed pipeline latency in clocks from pixel input to pixel output (informational; not overridable)

Ports:
- clk  in  1  system clock (one clock domain)
- rst  in  1  synchronous, active-low reset
- pix_x  in  10  current pixel column, 0..639 when active
- pix_y  in  10  current pixel line, 0..479 when active
- pix_active  in  1  visible-area flag
- h_sync_in  in  1  horizontal sync from timing generator
- v_sync_in  in  1  vertical sync from timing generator
- vram_read_address  out  12  character cell address = row*80+col
- vram_read_data  in  8  ASCII code; synchronous RAM, valid one clock after the address is presented
- font_address  out  12  {ascii[7:0], glyph_line[3:0]}
- font_data  in  8  glyph row bits, bit 7 = leftmost pixel; valid one clock after the address
- color_data  in  16  [7:0] foreground RGB332, [15:8] background RGB332
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- rgb_out  out  8  RGB332 pixel
- h_sync_out  out  1  h_sync_in delayed LAT
- v_sync_out  out  1  v_sync_in delayed LAT
- active_out  out  1  pix_active delayed LAT

Behaviour:
- Reset (rst=0 at a rising edge):
  - All pipeline registers, outputs, the blink counter and the blink phase clear to 0.
  - rgb_out, h_sync_out, v_sync_out, active_out, vram_read_address and font_address read 0 from the next cycle.
  - Reset mid-frame discards every in-flight pixel. The first valid output appears LAT cycles after rst returns high.
- Decode:
  - col = pix_x[9:3], row = pix_y[8:4], glyph_line = pix_y[3:0], sub = pix_x[2:0].
  - The address product is formed as (row<<6)+(row<<4)+col. No multiplier.
- In-range: pix_active=1, col<COLS and row<ROWS. Out-of-range active pixels output background colour, and vram_read_address is driven 0 for them.
- Pipeline, pixel presented in cycle T:
  - T+1: vram_read_address registered. glyph_line, sub, the in-range/active flags, syncs and the cursor-hit flag carried forward.
  - T+2: vram_read_data valid.
  - T+3: font_address = {vram_read_data, glyph_line} registered.
  - T+4: font_data valid.
  - T+5: rgb_out registered.
- Pixel select: bit = font_data[7-sub].
  - rgb_out = fg if (bit | cursor_on) else bg.
  - rgb_out = 0 when the delayed active flag is 0.
  - color_data is sampled at the T+4→T+5 edge; a change affects the very next output pixel.
- Cursor:
  - cursor_on = cursor_en & blink_phase & (col==cursor_col) & (row==cursor_row) & (glyph_line>=14).
  - Evaluated at T, delayed with the pixel.
  - cursor_col ≥ COLS or cursor_row ≥ ROWS never matches.
- Blink:
  - A frame event is a rising edge of v_sync_in, detected against a registered copy.
  - A 5-bit frame counter increments on each event.
  - On the event where the counter equals BLINK_FRAMES-1, the counter wraps to 0 and blink_phase toggles.
  - Phase is 0 after reset, so the cursor is hidden for the first BLINK_FRAMES frames.
- Syncs and active: pure LAT-stage shift registers. Sync polarity is unchanged.
- Back-to-back: one pixel accepted per clock, with no stalls and no backpressure. Every cycle's input produces exactly one output LAT cycles later.
- VRAM writes concurrent with reads: the RAM's read-during-write result is used as is. Stale characters are tolerated for one frame.

Test Plan:
- Reset held 3 cycles with random inputs -> rgb_out=0, syncs=0, active_out=0. First valid pixel exactly 5 clocks after rst=1.
- VRAM model with 0x41 at address 0, font row 3 of 0x41 = 0xA5, color_data=0x00E0 (bg 0x00, fg 0xE0); pixels x=0..7, y=3 -> font_address=0x413 at T+3; rgb_out sequence E0,00,E0,00,00,E0,00,E0 starting at T+5.
- Pixel x=639, y=479 -> vram_read_address = 29*80+79 = 2399, glyph_line = 15. Pixel x=640 with active forced -> background output, address 0.
- cursor_en=1, cursor (col 5, row 2), 32 v_sync rising edges -> cell (5,2) lines 14-15 all fg, lines 0-13 follow glyph. After 32 more edges -> underline gone.
- pix_active=0 with a nonzero glyph -> rgb_out=0. h_sync_in pulse pattern reproduced on h_sync_out shifted exactly 5 clocks.
- rst deasserted/asserted mid-line -> outputs 0 the next cycle, blink counter and phase return to 0, no stale pixel emitted after release.
